// File: rtl/decode_6466b_rx_fsm_if.sv
// Block-in / XGMII-out bundle of the 64b/66b receive decoder.
interface decode_6466b_rx_fsm_if #(
    parameter int DATA_WIDTH    = 64,
    parameter int ERR_CNT_WIDTH = 16
);
    logic [63:0]              i_rxd;
    logic [1:0]               i_rx_header;
    logic                     i_rx_valid;
    logic [DATA_WIDTH-1:0]    o_rxd;
    logic [DATA_WIDTH/8-1:0]  o_rxctl;
    logic                     o_rx_valid;
    logic [ERR_CNT_WIDTH-1:0] o_err_count;

    modport master (output i_rxd, i_rx_header, i_rx_valid,
                    input  o_rxd, o_rxctl, o_rx_valid, o_err_count);
    modport slave  (input  i_rxd, i_rx_header, i_rx_valid,
                    output o_rxd, o_rxctl, o_rx_valid, o_err_count);
endinterface

// File: rtl/decode_6466b_rx_fsm.sv
// 64b/66b receive decoder: block classify/decode, Clause 49 RX FSM with one-block lookahead,
// XGMII output at 64b or as two 32b half-beats.
module decode_6466b_rx_fsm #(
    parameter int DATA_WIDTH    = 64,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                 i_rxc,
    input  logic                 i_reset,
    input  logic                 i_init_done,
    decode_6466b_rx_fsm_if.slave bus
);
    localparam logic [1:0]  SYNC_DATA = 2'b01;
    localparam logic [1:0]  SYNC_CTL  = 2'b10;
    localparam logic [63:0] LBLOCK_R  = 64'h0100009C_0100009C;
    localparam logic [7:0]  LBLOCK_C  = 8'h11;
    localparam logic [63:0] EBLOCK_R  = {8{8'hFE}};
    localparam logic [7:0]  EBLOCK_C  = 8'hFF;
    localparam logic [7:0]  BT_IDLE = 8'h1E, BT_O4 = 8'h2D, BT_S4 = 8'h33, BT_O0O4 = 8'h55,
                            BT_O0S4 = 8'h66, BT_S0 = 8'h78, BT_O0 = 8'h4B,
                            BT_T0 = 8'h87, BT_T1 = 8'h99, BT_T2 = 8'hAA, BT_T3 = 8'hB4,
                            BT_T4 = 8'hCC, BT_T5 = 8'hD2, BT_T6 = 8'hE1, BT_T7 = 8'hFF;

    typedef enum logic [2:0] {CL_C, CL_S, CL_T, CL_D, CL_E} blk_cls_t;
    typedef enum logic [2:0] {RX_INIT, RX_C, RX_D, RX_T, RX_E} rx_state_t;

    // {illegal, xgmii byte} for a 7b control char / 4b O code
    function automatic logic [8:0] cc(input logic [6:0] c);
        case (c)
            7'h00:   return {1'b0, 8'h07};
            7'h1E:   return {1'b0, 8'hFE};
            default: return {1'b1, 8'hFE};
        endcase
    endfunction

    function automatic logic [8:0] oc(input logic [3:0] o);
        case (o)
            4'h0:    return {1'b0, 8'h9C};
            4'hF:    return {1'b0, 8'h5C};
            default: return {1'b1, 8'h9C};
        endcase
    endfunction

    logic [63:0]              w_in, w_dd, w_blk;
    logic [7:0]               w_dc, w_blkc;
    blk_cls_t                 w_cls;
    logic                     w_acc, w_busy, w_emit, w_err_inc;
    rx_state_t                r_state, w_next;
    logic                     r_s0_vld;
    logic [63:0]              r_s0_d;
    logic [7:0]               r_s0_c;
    blk_cls_t                 r_s0_cls;
    logic [ERR_CNT_WIDTH-1:0] r_err;
    logic [DATA_WIDTH-1:0]    r_rxd;
    logic [DATA_WIDTH/8-1:0]  r_rxc;
    logic                     r_vld;

    assign w_in  = bus.i_rxd;
    assign w_acc = bus.i_rx_valid & ~w_busy;

    always_comb begin : dec
        logic [8:0]  t;
        logic [63:0] sh;
        logic [7:0]  cmask;
        logic [2:0]  n;
        logic        bad;
        t = '0; sh = '0; cmask = '0; n = '0; bad = 1'b0;
        w_dd = w_in; w_dc = 8'h00; w_cls = CL_E;
        if (bus.i_rx_header == SYNC_DATA) begin
            w_cls = CL_D;
        end else if (bus.i_rx_header == SYNC_CTL) begin
            case (w_in[7:0])
                BT_IDLE: begin w_cls = CL_C; w_dc = 8'hFF; cmask = 8'hFF; end
                BT_O4: begin
                    w_cls = CL_C; w_dc = 8'h1F; cmask = 8'h0F;
                    t = oc(w_in[39:36]); w_dd[39:32] = t[7:0]; bad = t[8];
                end
                BT_S4: begin w_cls = CL_S; w_dc = 8'h1F; cmask = 8'h0F; w_dd[39:32] = 8'hFB; end
                BT_O0O4: begin
                    w_cls = CL_C; w_dc = 8'h11;
                    t = oc(w_in[39:36]); w_dd[39:32] = t[7:0]; bad = t[8];
                    t = oc(w_in[35:32]); w_dd[7:0] = t[7:0]; bad = bad | t[8];
                end
                BT_O0S4: begin
                    w_cls = CL_S; w_dc = 8'h11; w_dd[39:32] = 8'hFB;
                    t = oc(w_in[35:32]); w_dd[7:0] = t[7:0]; bad = t[8];
                end
                BT_S0: begin w_cls = CL_S; w_dc = 8'h01; w_dd[7:0] = 8'hFB; end
                BT_O0: begin
                    w_cls = CL_C; w_dc = 8'hF1; cmask = 8'hF0;
                    t = oc(w_in[35:32]); w_dd[7:0] = t[7:0]; bad = t[8];
                end
                BT_T0, BT_T1, BT_T2, BT_T3, BT_T4, BT_T5, BT_T6, BT_T7: begin
                    case (w_in[7:0])
                        BT_T1: n = 3'd1;  BT_T2: n = 3'd2;  BT_T3: n = 3'd3;
                        BT_T4: n = 3'd4;  BT_T5: n = 3'd5;  BT_T6: n = 3'd6;
                        BT_T7: n = 3'd7;  default: n = 3'd0;
                    endcase
                    w_cls = CL_T; w_dc = 8'hFF << n; cmask = 8'hFE << n;
                    w_dd = {8'h00, w_in[63:8]};
                    w_dd[8*n +: 8] = 8'hFD;
                    sh = w_in >> (7'd8 + {1'b0, n, 3'b000});
                    bad = |(sh[6:0] & (7'h7F >> n));
                end
                default: w_cls = CL_E;
            endcase
            // 7b control chars always sit at bit 8+7*lane in every block format
            for (int k = 0; k < 8; k++) begin
                if (cmask[k]) begin
                    t = cc(w_in[8+7*k +: 7]);
                    w_dd[8*k +: 8] = t[7:0];
                    bad = bad | t[8];
                end
            end
            if (bad) w_cls = CL_E;
        end
    end

    always_comb begin
        w_next = r_state; w_emit = 1'b0; w_err_inc = 1'b0;
        w_blk = r_s0_d; w_blkc = r_s0_c;
        if (!i_init_done) begin
            w_next = RX_INIT;
            if (w_acc) begin w_emit = 1'b1; w_blk = LBLOCK_R; w_blkc = LBLOCK_C; end
        end else if (w_acc && r_s0_vld) begin
            w_emit = 1'b1;
            case (r_state)
                RX_D:    w_next = (r_s0_cls == CL_D) ? RX_D :
                                  (r_s0_cls == CL_T && (w_cls == CL_C || w_cls == CL_S)) ? RX_T : RX_E;
                RX_E:    w_next = (r_s0_cls == CL_C) ? RX_C : (r_s0_cls == CL_D) ? RX_D :
                                  (r_s0_cls == CL_T && (w_cls == CL_C || w_cls == CL_S)) ? RX_T : RX_E;
                default: w_next = (r_s0_cls == CL_C) ? RX_C : (r_s0_cls == CL_S) ? RX_D : RX_E;
            endcase
            if (w_next == RX_E) begin w_blk = EBLOCK_R; w_blkc = EBLOCK_C; w_err_inc = 1'b1; end
        end
    end

    always_ff @(posedge i_rxc) begin
        if (i_reset) begin
            r_state  <= RX_INIT;
            r_s0_vld <= 1'b0;
            r_s0_d   <= '0;
            r_s0_c   <= '0;
            r_s0_cls <= CL_E;
            r_err    <= '0;
        end else begin
            r_state <= w_next;
            if (!i_init_done) begin
                r_s0_vld <= 1'b0;
            end else if (w_acc) begin
                r_s0_vld <= 1'b1;
                r_s0_d   <= w_dd;
                r_s0_c   <= w_dc;
                r_s0_cls <= w_cls;
            end
            if (w_err_inc && r_err != '1) r_err <= r_err + 1'b1;
        end
    end

    generate
        if (DATA_WIDTH == 64) begin : g_w64
            assign w_busy = 1'b0;
            always_ff @(posedge i_rxc) begin
                if (i_reset) begin
                    r_rxd <= LBLOCK_R;
                    r_rxc <= LBLOCK_C;
                    r_vld <= 1'b0;
                end else begin
                    r_vld <= w_emit;
                    if (w_emit) begin r_rxd <= w_blk; r_rxc <= w_blkc; end
                end
            end
        end else if (DATA_WIDTH == 32) begin : g_w32
            logic [31:0] r_hi;
            logic [3:0]  r_hic;
            logic        r_hi_pend;
            // an accept landing on the high-half beat is dropped
            assign w_busy = r_hi_pend;
            always_ff @(posedge i_rxc) begin
                if (i_reset) begin
                    r_rxd     <= LBLOCK_R[31:0];
                    r_rxc     <= LBLOCK_C[3:0];
                    r_vld     <= 1'b0;
                    r_hi      <= '0;
                    r_hic     <= '0;
                    r_hi_pend <= 1'b0;
                end else if (r_hi_pend) begin
                    r_rxd     <= r_hi;
                    r_rxc     <= r_hic;
                    r_vld     <= 1'b1;
                    r_hi_pend <= 1'b0;
                end else begin
                    r_vld     <= w_emit;
                    r_hi_pend <= w_emit;
                    if (w_emit) begin
                        r_rxd <= w_blk[31:0];
                        r_rxc <= w_blkc[3:0];
                        r_hi  <= w_blk[63:32];
                        r_hic <= w_blkc[7:4];
                    end
                end
            end
        end else begin : g_bad_width
            $error("decode_6466b_rx_fsm: DATA_WIDTH must be 64 or 32");
        end
    endgenerate

    assign bus.o_rxd       = r_rxd;
    assign bus.o_rxctl     = r_rxc;
    assign bus.o_rx_valid  = r_vld;
    assign bus.o_err_count = r_err;
endmodule

// File: tb/tb_decode_6466b_rx_fsm.sv
// Directed bench: 64b instance for framing/error paths, 32b instance with a 2-bit counter for half-beats.
module tb_decode_6466b_rx_fsm;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, init_a, rst_b, init_b;
    int   checks = 0;
    int   failures = 0;

    decode_6466b_rx_fsm_if #(.DATA_WIDTH(64), .ERR_CNT_WIDTH(16)) bus_a ();
    decode_6466b_rx_fsm_if #(.DATA_WIDTH(32), .ERR_CNT_WIDTH(2))  bus_b ();

    decode_6466b_rx_fsm #(.DATA_WIDTH(64), .ERR_CNT_WIDTH(16)) dut_a (
        .i_rxc(clk), .i_reset(rst_a), .i_init_done(init_a), .bus(bus_a.slave));
    decode_6466b_rx_fsm #(.DATA_WIDTH(32), .ERR_CNT_WIDTH(2)) dut_b (
        .i_rxc(clk), .i_reset(rst_b), .i_init_done(init_b), .bus(bus_b.slave));

    localparam logic [1:0]  HC = 2'b10, HD = 2'b01, HX = 2'b11;
    localparam logic [63:0] IDLE_B  = 64'h0000_0000_0000_001E;
    localparam logic [63:0] ERRCH_B = 64'h0000_0000_0000_1E1E;
    localparam logic [63:0] BADCH_B = 64'h0000_0000_0000_051E;
    localparam logic [63:0] S0_B    = 64'h7766_5544_3322_1178;
    localparam logic [63:0] D1_B    = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] D2_B    = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] T3_B    = 64'h0000_0000_CCBB_AAB4;
    localparam logic [63:0] T7_B    = 64'h6655_4433_2211_00FF;
    localparam logic [63:0] IDLE_X  = 64'h0707_0707_0707_0707;
    localparam logic [63:0] ERRCH_X = 64'h0707_0707_0707_07FE;
    localparam logic [63:0] S0_X    = 64'h7766_5544_3322_11FB;
    localparam logic [63:0] T3_X    = 64'h0707_0707_FDCC_BBAA;
    localparam logic [63:0] E_X     = 64'hFEFE_FEFE_FEFE_FEFE;
    localparam logic [63:0] L_X     = 64'h0100_009C_0100_009C;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step_a(input logic v, input logic [1:0] h, input logic [63:0] d);
        bus_a.i_rx_valid = v; bus_a.i_rx_header = h; bus_a.i_rxd = d;
        @(posedge clk); #1;
    endtask

    task automatic step_b(input logic v, input logic [1:0] h, input logic [63:0] d);
        bus_b.i_rx_valid = v; bus_b.i_rx_header = h; bus_b.i_rxd = d;
        @(posedge clk); #1;
    endtask

    task automatic ca(input string tag, input logic [63:0] d, input logic [7:0] c, input logic v);
        chk({tag, "_rxd"}, bus_a.o_rxd, d);
        chk({tag, "_ctl"}, {56'd0, bus_a.o_rxctl}, {56'd0, c});
        chk({tag, "_vld"}, {63'd0, bus_a.o_rx_valid}, {63'd0, v});
    endtask

    task automatic cb(input string tag, input logic [31:0] d, input logic [3:0] c, input logic v);
        chk({tag, "_rxd"}, {32'd0, bus_b.o_rxd}, {32'd0, d});
        chk({tag, "_ctl"}, {60'd0, bus_b.o_rxctl}, {60'd0, c});
        chk({tag, "_vld"}, {63'd0, bus_b.o_rx_valid}, {63'd0, v});
    endtask

    initial begin
        rst_a = 1'b1; init_a = 1'b0; rst_b = 1'b1; init_b = 1'b1;
        bus_a.i_rx_valid = 1'b0; bus_a.i_rx_header = HC; bus_a.i_rxd = '0;
        bus_b.i_rx_valid = 1'b0; bus_b.i_rx_header = HC; bus_b.i_rxd = '0;
        step_a(0, HC, IDLE_B); step_a(0, HC, IDLE_B);
        ca("rst", L_X, 8'h11, 1'b0);
        chk("rst_err", {48'd0, bus_a.o_err_count}, 64'd0);

        // not initialised: local fault on every accept
        rst_a = 1'b0;
        step_a(1, HC, IDLE_B);  ca("noinit", L_X, 8'h11, 1'b1);
        step_a(0, HC, IDLE_B);  chk("noinit_gap_vld", {63'd0, bus_a.o_rx_valid}, 64'd0);

        // first accept only primes the lookahead
        init_a = 1'b1;
        step_a(1, HC, IDLE_B);  ca("prime", L_X, 8'h11, 1'b0);
        step_a(1, HC, IDLE_B);  ca("idle", IDLE_X, 8'hFF, 1'b1);
        step_a(0, HC, IDLE_B);  ca("hold", IDLE_X, 8'hFF, 1'b0);

        // frame IDLE,S0,D,D,T3,IDLE
        step_a(1, HC, S0_B);    ca("f_idle", IDLE_X, 8'hFF, 1'b1);
        step_a(1, HD, D1_B);    ca("f_s0", S0_X, 8'h01, 1'b1);
        step_a(1, HD, D2_B);    ca("f_d1", D1_B, 8'h00, 1'b1);
        step_a(1, HC, T3_B);    ca("f_d2", D2_B, 8'h00, 1'b1);
        step_a(1, HC, IDLE_B);  ca("f_t3", T3_X, 8'hF8, 1'b1);
        step_a(1, HC, IDLE_B);  ca("f_idle2", IDLE_X, 8'hFF, 1'b1);
        chk("f_err", {48'd0, bus_a.o_err_count}, 64'd0);

        // T7 followed by data is an error; data afterwards recovers
        step_a(1, HC, S0_B);
        step_a(1, HD, D1_B);
        step_a(1, HC, T7_B);    ca("t7_d1", D1_B, 8'h00, 1'b1);
        step_a(1, HD, D2_B);    ca("t7_e", E_X, 8'hFF, 1'b1);
        chk("t7_err", {48'd0, bus_a.o_err_count}, 64'd1);
        step_a(1, HC, T3_B);    ca("t7_rec", D2_B, 8'h00, 1'b1);
        step_a(1, HC, IDLE_B);  ca("t7_t3", T3_X, 8'hF8, 1'b1);
        step_a(1, HC, IDLE_B);  ca("t7_idle", IDLE_X, 8'hFF, 1'b1);

        // bad sync header mid-frame
        step_a(1, HC, S0_B);
        step_a(1, HD, D1_B);
        step_a(1, HX, D1_B);    ca("hx_d1", D1_B, 8'h00, 1'b1);
        step_a(1, HD, D2_B);    ca("hx_e", E_X, 8'hFF, 1'b1);
        chk("hx_err", {48'd0, bus_a.o_err_count}, 64'd2);
        step_a(1, HC, T3_B);    ca("hx_rec", D2_B, 8'h00, 1'b1);
        step_a(1, HC, IDLE_B);  ca("hx_t3", T3_X, 8'hF8, 1'b1);
        step_a(1, HC, IDLE_B);

        // /E/ char inside a C block is legal; an unknown char is not
        step_a(1, HC, ERRCH_B);
        step_a(1, HC, IDLE_B);  ca("errch", ERRCH_X, 8'hFF, 1'b1);
        step_a(1, HC, BADCH_B);
        step_a(1, HC, IDLE_B);  ca("badch", E_X, 8'hFF, 1'b1);
        chk("badch_err", {48'd0, bus_a.o_err_count}, 64'd3);
        step_a(1, HC, IDLE_B);  ca("badch_rec", IDLE_X, 8'hFF, 1'b1);

        // losing init: local fault, counter held, restart primes again
        init_a = 1'b0;
        step_a(1, HC, IDLE_B);  ca("lost", L_X, 8'h11, 1'b1);
        chk("lost_err", {48'd0, bus_a.o_err_count}, 64'd3);
        init_a = 1'b1;
        step_a(1, HC, IDLE_B);  chk("reprime_vld", {63'd0, bus_a.o_rx_valid}, 64'd0);
        step_a(1, HC, IDLE_B);  ca("reinit", IDLE_X, 8'hFF, 1'b1);

        // 32b half-beat instance
        step_b(0, HC, IDLE_B);  cb("b_rst", 32'h0100009C, 4'h1, 1'b0);
        chk("b_rst_err", {62'd0, bus_b.o_err_count}, 64'd0);
        rst_b = 1'b0;
        step_b(1, HC, IDLE_B);  chk("b_prime_vld", {63'd0, bus_b.o_rx_valid}, 64'd0);
        step_b(0, HC, IDLE_B);
        step_b(1, HC, S0_B);    cb("b_idle_lo", 32'h07070707, 4'hF, 1'b1);
        step_b(0, HC, IDLE_B);  cb("b_idle_hi", 32'h07070707, 4'hF, 1'b1);
        step_b(1, HC, T3_B);    cb("b_s0_lo", 32'h332211FB, 4'h1, 1'b1);
        step_b(0, HC, IDLE_B);  cb("b_s0_hi", 32'h77665544, 4'h0, 1'b1);
        step_b(1, HC, IDLE_B);  cb("b_t3_lo", 32'hFDCCBBAA, 4'h8, 1'b1);
        step_b(0, HC, IDLE_B);  cb("b_t3_hi", 32'h07070707, 4'hF, 1'b1);
        step_b(0, HC, IDLE_B);  chk("b_gap_vld", {63'd0, bus_b.o_rx_valid}, 64'd0);

        // back-to-back accept is dropped (the bad block never reaches the FSM)
        step_b(1, HC, IDLE_B);
        step_b(1, HX, D1_B);    cb("b_drop_hi", 32'h07070707, 4'hF, 1'b1);
        step_b(0, HC, IDLE_B);
        step_b(1, HC, IDLE_B);  cb("b_drop_next", 32'h07070707, 4'hF, 1'b1);
        chk("b_drop_err", {62'd0, bus_b.o_err_count}, 64'd0);
        step_b(0, HC, IDLE_B);

        // counter saturation
        step_b(1, HX, D1_B);    step_b(0, HC, IDLE_B);
        step_b(1, HX, D1_B);    cb("b_e_lo", 32'hFEFEFEFE, 4'hF, 1'b1);
        chk("b_err1", {62'd0, bus_b.o_err_count}, 64'd1);
        step_b(0, HC, IDLE_B);
        step_b(1, HX, D1_B);    step_b(0, HC, IDLE_B);
        step_b(1, HX, D1_B);    chk("b_err3", {62'd0, bus_b.o_err_count}, 64'd3);
        step_b(0, HC, IDLE_B);
        step_b(1, HX, D1_B);    chk("b_err_sat", {62'd0, bus_b.o_err_count}, 64'd3);
        step_b(0, HC, IDLE_B);

        // reset between the halves drops the pending high half
        step_b(1, HX, D1_B);
        rst_b = 1'b1;
        step_b(0, HC, IDLE_B);  cb("b_midrst", 32'h0100009C, 4'h1, 1'b0);
        chk("b_midrst_err", {62'd0, bus_b.o_err_count}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
